// File: rtl/ctrl_opcode_encoder_pkg.sv
// Shared constants for the control-bundle re-encoder: field positions, legal
// bundles, opcodes and the bundle-to-opcode map.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 9;

  localparam int unsigned CTRL_REGDST   = 8;
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_MEMREAD  = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_ILLEGAL = 6'h3F;

  // Bundles built from field positions so they read like the decoder's truth table
  localparam logic [CTRL_W-1:0] CTRL_RTYPE = CTRL_W'((1 << CTRL_REGDST) | (1 << CTRL_REGWRITE)
                                                   | (1 << CTRL_ALUOP_HI));
  localparam logic [CTRL_W-1:0] CTRL_LW    = CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUSRC)
                                                   | (1 << CTRL_MEMREAD) | (1 << CTRL_MEMTOREG));
  localparam logic [CTRL_W-1:0] CTRL_SW    = CTRL_W'((1 << CTRL_ALUSRC) | (1 << CTRL_MEMWRITE));
  localparam logic [CTRL_W-1:0] CTRL_BEQ   = CTRL_W'((1 << CTRL_BRANCH) | (1 << CTRL_ALUOP_LO));
  localparam logic [CTRL_W-1:0] CTRL_ORI   = CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_ALUSRC)
                                                   | (1 << CTRL_ALUOP_HI) | (1 << CTRL_ALUOP_LO));

  typedef struct packed {
    logic       illegal;
    logic [5:0] opcode;
  } enc_t;

  // Exact match only: any stray bit makes the bundle illegal.
  function automatic enc_t ctrl_to_opcode(input logic [CTRL_W-1:0] ctrl);
    enc_t r;
    r.illegal = 1'b0;
    case (ctrl)
      CTRL_RTYPE: r.opcode = OP_RTYPE;
      CTRL_LW:    r.opcode = OP_LW;
      CTRL_SW:    r.opcode = OP_SW;
      CTRL_BEQ:   r.opcode = OP_BEQ;
      CTRL_ORI:   r.opcode = OP_ORI;
      default: begin
        r.opcode  = OP_ILLEGAL;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_opcode_encoder_if.sv
// Valid/ready streams of the re-encoder: control bundles in, opcodes out.
interface ctrl_opcode_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_opcode;
  logic       out_illegal;

  modport master (
    output in_valid, in_ctrl, out_ready,
    input  in_ready, out_valid, out_opcode, out_illegal
  );

  modport slave (
    input  in_valid, in_ctrl, out_ready,
    output in_ready, out_valid, out_opcode, out_illegal
  );
endinterface

// File: rtl/ctrl_opcode_encoder_sync_fifo.sv
// Single-clock FIFO with separate occupancy count and synchronous flush;
// refuses pushes when full and pops when empty or flushing.
module sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/ctrl_opcode_encoder.sv
// Re-encodes captured control bundles into MIPS opcodes through a small FIFO.
// Define CTRL_ENC_ERRCNT_EN to add the saturating err_cnt illegal-bundle counter.
module ctrl_opcode_encoder
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  ctrl_opcode_encoder_if.slave  bus
`ifdef CTRL_ENC_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]      err_cnt
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("ctrl_opcode_encoder: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  enc_t enc;
  enc_t head;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign enc          = ctrl_to_opcode(bus.in_ctrl);
  assign bus.in_ready = !full && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !empty;
  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_illegal = head.illegal;

  sync_fifo #(
    .WIDTH(7),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .wdata(enc),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

`ifdef CTRL_ENC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && enc.illegal && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
